// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencer controller and its datapath.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } seq_state_t;

    // Width of a counter that must hold every value from 0 to w inclusive.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_chain.sv
// Parallel-load shift register that shifts left on enable; the serial tap is the MSB.
module shift_chain #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    output logic         msb
);

    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_d;

    // Load wins over shift; the controller never requests both in one cycle.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb = shreg_q[W-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serialises one W-bit word per valid/ready handshake, MSB first, one bit per shift_en strobe,
// with busy/done framing status and an abort path.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic                  shift_en,
    input  logic                  abort,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  busy,
    output logic                  done,
    output logic [cnt_w(W)-1:0]   bits_left
);

    localparam int unsigned CW = cnt_w(W);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            sout_q;
    logic            sout_d;
    logic            sout_valid_q;
    logic            sout_valid_d;
    logic            done_q;
    logic            done_d;
    logic            chain_load;
    logic            chain_shift;
    logic            chain_msb;

    shift_chain #(
        .W (W)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .load      (chain_load),
        .load_data (in_data),
        .shift     (chain_shift),
        .msb       (chain_msb)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;
        chain_load   = 1'b0;
        chain_shift  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    chain_load = 1'b1;
                    cnt_d      = CW'(W);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // shift_en is deliberately ignored here so the first bit is never lost.
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (shift_en) begin
                    chain_shift  = 1'b1;
                    sout_d       = chain_msb;
                    sout_valid_d = 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == LOAD) || (state_q == SHIFT);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;
    assign bits_left  = cnt_q;

    // A shift with an empty counter would wrap; the DONE transition must prevent it.
    a_no_wrap: assert property (@(posedge clk) disable iff (reset)
        (state_q == SHIFT) |-> (cnt_q != '0));

    a_done_in_done: assert property (@(posedge clk) disable iff (reset)
        done_q |-> (state_q == DONE));

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: table-driven word streams, hand-written corner sequences and random
// stimulus, all compared against a transaction-level model of the serialiser.
module tb_shift_seq_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          shift_en;
    logic          abort;
    logic          sout;
    logic          sout_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] bits_left;

    always #5 clk = ~clk;

    shift_seq_ctrl #(
        .W (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .abort      (abort),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done),
        .bits_left  (bits_left)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle, 1 load, 2 shifting, 3 done; m_sent bits of m_word emitted so far.
    int           m_mode = 0;
    logic [W-1:0] m_word = '0;
    int           m_sent = 0;
    logic         m_sout = 1'b0;
    logic         m_sv   = 1'b0;

    int           cyc_n = 0;
    int           nbits, ndone, nhs;
    logic [31:0]  stream;
    int           hs_at[$];
    int           done_at[$];

    typedef struct {
        logic [W-1:0] data;
        int           period;
        logic [W-1:0] exp_bits;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic se,
                              input logic ab, input logic rs);
        if (rs) begin
            m_mode = 0;
            m_sent = 0;
            m_sout = 1'b0;
            m_sv   = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    m_sv = 1'b0;
                    if (v) begin
                        m_word = d;
                        m_sent = 0;
                        m_mode = 1;
                    end
                end
                1: begin
                    m_sv   = 1'b0;
                    m_mode = ab ? 0 : 2;
                end
                2: begin
                    if (ab) begin
                        m_mode = 0;
                        m_sv   = 1'b0;
                    end else if (se) begin
                        m_sout = m_word[W-1-m_sent];
                        m_sent++;
                        m_sv = 1'b1;
                        if (m_sent == W) m_mode = 3;
                    end else begin
                        m_sv = 1'b0;
                    end
                end
                default: begin
                    m_sv   = 1'b0;
                    m_mode = 0;
                end
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model, sample DUT #1 after the edge and compare.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic se,
                       input logic ab, input logic rs);
        int exp_left;
        in_valid = v;
        in_data  = d;
        shift_en = se;
        abort    = ab;
        reset    = rs;
        if (!rs && v && in_ready) begin
            nhs++;
            hs_at.push_back(cyc_n + 1);
        end
        model_step(v, d, se, ab, rs);
        @(posedge clk);
        #1;
        cyc_n++;
        exp_left = (m_mode == 1 || m_mode == 2) ? (W - m_sent) : 0;
        check("sout", sout, m_sout);
        check("sout_valid", sout_valid, m_sv);
        check("done", done, m_mode == 3);
        check("busy", busy, m_mode == 1 || m_mode == 2);
        check("in_ready", in_ready, m_mode == 0);
        check("bits_left", bits_left, exp_left);
        if (sout_valid === 1'b1) begin
            stream = {stream[30:0], sout};
            nbits++;
        end
        if (done === 1'b1) begin
            ndone++;
            done_at.push_back(cyc_n);
        end
    endtask

    task automatic clr();
        nbits  = 0;
        ndone  = 0;
        nhs    = 0;
        stream = '1;
        hs_at.delete();
        done_at.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int last_sv;
        logic [W-1:0] d0;

        vecs[0] = '{data: 8'hA5, period: 1, exp_bits: 8'hA5};
        vecs[1] = '{data: 8'hF0, period: 3, exp_bits: 8'hF0};
        vecs[2] = '{data: 8'h3C, period: 2, exp_bits: 8'h3C};
        vecs[3] = '{data: 8'h81, period: 5, exp_bits: 8'h81};

        clr();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_bits_left", bits_left, 0);

        // Table-driven words at several shift_en paces.
        foreach (vecs[i]) begin
            clr();
            cyc(1'b1, vecs[i].data, vecs[i].period == 1, 1'b0, 1'b0);
            k = 1;
            last_sv = -1;
            while (ndone == 0 && k < 200) begin
                cyc(1'b0, '0, (k % vecs[i].period) == 0, 1'b0, 1'b0);
                if (sout_valid === 1'b1) begin
                    check("bits_left_step", bits_left, W - nbits);
                    if (last_sv >= 0) check("sv_spacing", cyc_n - last_sv, vecs[i].period);
                    last_sv = cyc_n;
                end
                k++;
            end
            check("vec_done_count", ndone, 1);
            check("vec_bit_count", nbits, W);
            check("vec_stream", stream[W-1:0], vecs[i].exp_bits);
            if (vecs[i].period == 1) check("vec_latency", done_at[0] - hs_at[0], W + 1);
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            check("vec_ready_after", in_ready, 1'b1);
        end

        // Back-to-back words with in_valid held.
        clr();
        k = 0;
        while (ndone < 2 && k < 60) begin
            cyc(1'b1, (nhs >= 1) ? 8'h80 : 8'h01, 1'b1, 1'b0, 1'b0);
            k++;
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("b2b_hs_count", hs_at.size(), 2);
        check("b2b_done_count", ndone, 2);
        check("b2b_bits", nbits, 2 * W);
        check("b2b_stream", stream[15:0], 16'h0180);
        check("b2b_hs_after_done", hs_at[1] - done_at[0], 2);
        check("b2b_spacing", hs_at[1] - hs_at[0], W + 3);

        // Abort after three bits, then a clean zero word.
        clr();
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("abort_bits_before", nbits, 3);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_sout_hold", sout, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("abort_no_done", ndone, 0);
        clr();
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (ndone == 0 && k < 40) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            k++;
        end
        check("post_abort_bits", nbits, W);
        check("post_abort_stream", stream[W-1:0], 8'h00);
        check("post_abort_done", ndone, 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset after five bits.
        clr();
        cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_bits_before", nbits, 5);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("rst_sout", sout, 1'b0);
        check("rst_sout_valid", sout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bits_left", bits_left, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_no_done", ndone, 0);

        // in_valid held through SHIFT and DONE with changing data: only one word accepted.
        clr();
        d0 = 8'h6B;
        cyc(1'b1, d0, 1'b1, 1'b0, 1'b0);
        k = 1;
        while (ndone == 0 && k < 60) begin
            cyc(1'b1, W'($urandom), (k % 2) == 0, 1'b0, 1'b0);
            k++;
        end
        check("hold_ready_in_done", in_ready, 1'b0);
        check("hold_hs_count", nhs, 1);
        check("hold_bits", nbits, W);
        check("hold_stream", stream[W-1:0], d0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
